eth_rx_mac_filter: RTL and testbench

- Receive-side stage directly downstream of the RMII Ethernet wrapper's RX_AXIS output; consumes 8-bit AXI-Stream frames and forwards only frames addressed to this node.
- Buffers the 6-byte destination MAC and compares it against local_mac, broadcast and, optionally, multicast; frames that fail the match are discarded whole.
- Forwarded frames are byte-identical to the input, including tuser (bad-frame flag) on the last byte.

---
 rtl/eth_pkg.sv | 17 +
 rtl/eth_rx_mac_filter_if.sv | 26 ++
 rtl/eth_rx_mac_filter_axis_out_reg.sv | 34 +++
 rtl/eth_rx_mac_filter.sv | 192 +++++++++++++++++++
 tb/tb_eth_rx_mac_filter.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet receive-path types and constants.
package eth_pkg;

    typedef logic [47:0] mac_addr_t;

    localparam mac_addr_t   ETH_BCAST_ADDR = '1;
    localparam int unsigned ETH_DST_LEN    = 6;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        REPLAY,
        PASS,
        DROP
    } rx_filt_state_t;

endpackage

// File: rtl/eth_rx_mac_filter_if.sv
// 8-bit AXI-Stream link with bad-frame flag on tuser.
interface eth_rx_mac_filter_if;

    logic [7:0] tdata;
    logic       tvalid;
    logic       tready;
    logic       tlast;
    logic       tuser;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        output tuser,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        input  tuser,
        output tready
    );

endinterface

// File: rtl/eth_rx_mac_filter_axis_out_reg.sv
// Single-stage registered AXI-Stream output (tdata/tlast/tuser).
// Loads whenever the stage is empty or being drained; payload is held
// stable while tvalid=1 and tready=0.
module axis_out_reg (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_valid,
    input  logic [7:0]                  i_data,
    input  logic                        i_last,
    input  logic                        i_user,
    output logic                        o_ready,
    eth_rx_mac_filter_if.master         m_axis
);

    assign o_ready = !m_axis.tvalid || m_axis.tready;

    // Output stage: take a new beat on each load opportunity.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_axis.tvalid <= 1'b0;
            m_axis.tdata  <= '0;
            m_axis.tlast  <= 1'b0;
            m_axis.tuser  <= 1'b0;
        end else if (o_ready) begin
            m_axis.tvalid <= i_valid;
            if (i_valid) begin
                m_axis.tdata <= i_data;
                m_axis.tlast <= i_last;
                m_axis.tuser <= i_user;
            end
        end
    end

endmodule

// File: rtl/eth_rx_mac_filter.sv
// Receive MAC destination filter: buffers the 6-byte destination address,
// forwards matching frames byte-identical and discards the rest whole.
// Optional statistics counters: define ETH_RX_MAC_FILTER_STATS_EN.
module eth_rx_mac_filter
    import eth_pkg::*;
#(
    parameter bit ACCEPT_BROADCAST = 1'b1,
    parameter bit ACCEPT_MULTICAST = 1'b0
`ifdef ETH_RX_MAC_FILTER_STATS_EN
    ,
    parameter int unsigned STAT_WIDTH = 32
`endif
) (
    input  logic                        clock50,
    input  logic                        reset,
    input  mac_addr_t                   local_mac,
    input  logic                        promisc,
    eth_rx_mac_filter_if.slave          s_axis,
    eth_rx_mac_filter_if.master         m_axis
`ifdef ETH_RX_MAC_FILTER_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0]       stat_accepted,
    output logic [STAT_WIDTH-1:0]       stat_dropped
`endif
);

    localparam logic [2:0] LAST_IDX = 3'(ETH_DST_LEN - 1);

    rx_filt_state_t r_state;
    rx_filt_state_t w_next;
    logic [2:0]     r_cnt;
    logic [2:0]     w_cnt_nxt;
    logic [7:0]     r_hdr [ETH_DST_LEN];
    mac_addr_t      r_mac;
    logic           r_promisc;
    logic           r_last5;
    logic           r_user5;

    mac_addr_t      w_dst;
    logic           w_match;
    logic           w_s_ready;
    logic           w_hdr_we;
    logic           w_acc_evt;
    logic           w_drop_evt;
    logic           w_load;
    logic [7:0]     w_odata;
    logic           w_olast;
    logic           w_ouser;
    logic           w_out_ready;

    assign s_axis.tready = w_s_ready;

    // Destination as it completes on byte 5 (current input byte is the last one).
    assign w_dst   = {r_hdr[0], r_hdr[1], r_hdr[2], r_hdr[3], r_hdr[4], s_axis.tdata};
    assign w_match = r_promisc
                  || (w_dst == r_mac)
                  || (ACCEPT_BROADCAST && (w_dst == ETH_BCAST_ADDR))
                  || (ACCEPT_MULTICAST && r_hdr[0][0]);

    // Next-state, input ready and output-stage feed.
    always_comb begin
        w_next     = r_state;
        w_cnt_nxt  = r_cnt;
        w_s_ready  = 1'b0;
        w_hdr_we   = 1'b0;
        w_acc_evt  = 1'b0;
        w_drop_evt = 1'b0;
        w_load     = 1'b0;
        w_odata    = '0;
        w_olast    = 1'b0;
        w_ouser    = 1'b0;
        unique case (r_state)
            IDLE, HDR: begin
                w_s_ready = 1'b1;
                if (s_axis.tvalid) begin
                    w_hdr_we  = 1'b1;
                    w_cnt_nxt = r_cnt + 3'd1;
                    if (r_cnt == LAST_IDX) begin
                        w_cnt_nxt = '0;
                        if (w_match) begin
                            w_next    = REPLAY;
                            w_acc_evt = 1'b1;
                        end else begin
                            w_drop_evt = 1'b1;
                            w_next     = s_axis.tlast ? IDLE : DROP;
                        end
                    end else if (s_axis.tlast) begin
                        w_cnt_nxt  = '0;
                        w_drop_evt = 1'b1;
                        w_next     = IDLE;
                    end else begin
                        w_next = HDR;
                    end
                end
            end
            REPLAY: begin
                w_load  = 1'b1;
                w_odata = r_hdr[r_cnt];
                if (r_cnt == LAST_IDX) begin
                    w_olast = r_last5;
                    w_ouser = r_user5;
                end
                if (w_out_ready) begin
                    w_cnt_nxt = r_cnt + 3'd1;
                    if (r_cnt == LAST_IDX) begin
                        w_cnt_nxt = '0;
                        w_next    = r_last5 ? IDLE : PASS;
                    end
                end
            end
            PASS: begin
                w_s_ready = w_out_ready;
                w_load    = s_axis.tvalid;
                w_odata   = s_axis.tdata;
                w_olast   = s_axis.tlast;
                w_ouser   = s_axis.tuser;
                if (s_axis.tvalid && w_out_ready && s_axis.tlast) begin
                    w_next = IDLE;
                end
            end
            DROP: begin
                w_s_ready = 1'b1;
                if (s_axis.tvalid && s_axis.tlast) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next    = IDLE;
                w_cnt_nxt = '0;
            end
        endcase
    end

    // State, byte counter and per-frame latched controls.
    always_ff @(posedge clock50) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_mac     <= '0;
            r_promisc <= 1'b0;
            r_last5   <= 1'b0;
            r_user5   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_nxt;
            if (w_hdr_we && (r_state == IDLE)) begin
                r_mac     <= local_mac;
                r_promisc <= promisc;
            end
            if (w_hdr_we && (r_cnt == LAST_IDX)) begin
                r_last5 <= s_axis.tlast;
                r_user5 <= s_axis.tuser;
            end
        end
    end

    // Header byte buffer; pure datapath, no reset needed.
    always_ff @(posedge clock50) begin
        if (w_hdr_we) begin
            r_hdr[r_cnt] <= s_axis.tdata;
        end
    end

    axis_out_reg u_out_reg (
        .clk     (clock50),
        .rst     (reset),
        .i_valid (w_load),
        .i_data  (w_odata),
        .i_last  (w_olast),
        .i_user  (w_ouser),
        .o_ready (w_out_ready),
        .m_axis  (m_axis)
    );

`ifdef ETH_RX_MAC_FILTER_STATS_EN
    // Frame accept/drop counters, free-running with wrap.
    always_ff @(posedge clock50) begin
        if (reset) begin
            stat_accepted <= '0;
            stat_dropped  <= '0;
        end else begin
            if (w_acc_evt) begin
                stat_accepted <= stat_accepted + 1'b1;
            end
            if (w_drop_evt) begin
                stat_dropped <= stat_dropped + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_eth_rx_mac_filter.sv
// Scoreboard bench for eth_rx_mac_filter: two instances (multicast off/on).
module tb_eth_rx_mac_filter;
    import eth_pkg::*;

    logic      clk = 1'b0;
    logic      rst;
    mac_addr_t r_mac;
    logic      r_promisc;
    logic      r_bp_en;

    int        n_checks = 0;
    int        n_fail   = 0;
    logic [9:0] q0[$];
    logic [9:0] q1[$];
    logic [9:0] e0;
    logic [9:0] e1;
    logic [7:0] r_frame [0:127];
    int        r_stalls;

    eth_rx_mac_filter_if s0 ();
    eth_rx_mac_filter_if m0 ();
    eth_rx_mac_filter_if s1 ();
    eth_rx_mac_filter_if m1 ();

`ifdef ETH_RX_MAC_FILTER_STATS_EN
    logic [31:0] w_acc0, w_drop0, w_acc1, w_drop1;
`endif

    always #5 clk = ~clk;

    eth_rx_mac_filter #(
        .ACCEPT_BROADCAST (1'b1),
        .ACCEPT_MULTICAST (1'b0)
    ) u_dut0 (
        .clock50   (clk),
        .reset     (rst),
        .local_mac (r_mac),
        .promisc   (r_promisc),
        .s_axis    (s0.slave),
        .m_axis    (m0.master)
`ifdef ETH_RX_MAC_FILTER_STATS_EN
        ,
        .stat_accepted (w_acc0),
        .stat_dropped  (w_drop0)
`endif
    );

    eth_rx_mac_filter #(
        .ACCEPT_BROADCAST (1'b1),
        .ACCEPT_MULTICAST (1'b1)
    ) u_dut1 (
        .clock50   (clk),
        .reset     (rst),
        .local_mac (r_mac),
        .promisc   (1'b0),
        .s_axis    (s1.slave),
        .m_axis    (m1.master)
`ifdef ETH_RX_MAC_FILTER_STATS_EN
        ,
        .stat_accepted (w_acc1),
        .stat_dropped  (w_drop1)
`endif
    );

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Scoreboard pop on every output transfer (sampled at negedge, transfer at next posedge).
    always @(negedge clk) begin
        if (m0.tvalid === 1'b1 && m0.tready === 1'b1) begin
            if (q0.size() == 0) begin
                check_val("dut0_spurious_beat", 64'(q0.size()), 64'd1);
            end else begin
                e0 = q0.pop_front();
                check_val("dut0_beat", 64'({m0.tdata, m0.tlast, m0.tuser}), 64'(e0));
            end
        end
        if (m1.tvalid === 1'b1 && m1.tready === 1'b1) begin
            if (q1.size() == 0) begin
                check_val("dut1_spurious_beat", 64'(q1.size()), 64'd1);
            end else begin
                e1 = q1.pop_front();
                check_val("dut1_beat", 64'({m1.tdata, m1.tlast, m1.tuser}), 64'(e1));
            end
        end
    end

    // Output backpressure generator for dut0.
    initial begin
        m0.tready = 1'b1;
        m1.tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (r_bp_en) m0.tready = 1'($urandom_range(0, 1));
            else         m0.tready = 1'b1;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "simulation time limit");
    end

    task automatic build(input mac_addr_t dst, input int n);
        for (int i = 0; i < 6; i++) r_frame[i] = dst[47 - 8*i -: 8];
        for (int i = 6; i < n; i++) r_frame[i] = 8'($urandom);
    endtask

    task automatic push_exp(input int sel, input int n, input bit user, input int cnt);
        logic [9:0] e;
        for (int i = 0; i < cnt; i++) begin
            e = {r_frame[i], (i == n - 1), ((i == n - 1) && user)};
            if (sel == 1) q1.push_back(e);
            else          q0.push_back(e);
        end
    endtask

    task automatic set_in(input int sel, input logic v, input logic [7:0] d, input logic l, input logic u);
        if (sel == 1) begin
            s1.tvalid = v; s1.tdata = d; s1.tlast = l; s1.tuser = u;
        end else begin
            s0.tvalid = v; s0.tdata = d; s0.tlast = l; s0.tuser = u;
        end
    endtask

    task automatic drive_frame(input int sel, input int n, input bit user, input int stop_after,
                               output int stalls);
        int g;
        logic rdy;
        stalls = 0;
        for (int i = 0; i < stop_after; i++) begin
            set_in(sel, 1'b1, r_frame[i], (i == n - 1), ((i == n - 1) && user));
            g = 0;
            forever begin
                @(negedge clk);
                rdy = (sel == 1) ? s1.tready : s0.tready;
                if (rdy) break;
                stalls++;
                g++;
                if (g > 2000) begin
                    check_val("input_accept_timeout", 64'(g), 64'd0);
                    set_in(sel, 1'b0, 8'h00, 1'b0, 1'b0);
                    return;
                end
            end
            @(posedge clk);
            #1;
        end
        set_in(sel, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic wait_drain(input int sel);
        int g;
        g = 0;
        while ((((sel == 1) ? q1.size() : q0.size()) != 0 ||
                ((sel == 1) ? m1.tvalid : m0.tvalid) == 1'b1) && g < 2000) begin
            @(posedge clk);
            #1;
            g++;
        end
        check_val("drain_queue_empty", 64'((sel == 1) ? q1.size() : q0.size()), 64'd0);
    endtask

    initial begin
        rst       = 1'b1;
        r_mac     = 48'h02_00_00_00_00_01;
        r_promisc = 1'b0;
        r_bp_en   = 1'b0;
        set_in(0, 1'b0, 8'h00, 1'b0, 1'b0);
        set_in(1, 1'b0, 8'h00, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        @(negedge clk);
        check_val("rst_m_tvalid", 64'(m0.tvalid), 64'd0);
        check_val("rst_m_tdata",  64'(m0.tdata),  64'd0);
        check_val("rst_m_tlast",  64'(m0.tlast),  64'd0);
        check_val("rst_m_tuser",  64'(m0.tuser),  64'd0);
        check_val("rst_s_tready", 64'(s0.tready), 64'd1);
        check_val("rst_state",    64'(u_dut0.r_state), 64'(IDLE));
`ifdef ETH_RX_MAC_FILTER_STATS_EN
        check_val("rst_stat_acc",  64'(w_acc0),  64'd0);
        check_val("rst_stat_drop", 64'(w_drop0), 64'd0);
`endif
        @(posedge clk);
        #1;

        // Unicast match, 64 bytes, output always ready.
        build(r_mac, 64);
        push_exp(0, 64, 1'b0, 64);
        drive_frame(0, 64, 1'b0, 64, r_stalls);
        check_val("unicast_replay_stall", 64'(r_stalls), 64'd6);
        wait_drain(0);

        // Destination mismatch: dropped, never stalls.
        build(48'h02_00_00_00_00_02, 40);
        drive_frame(0, 40, 1'b0, 40, r_stalls);
        check_val("mismatch_no_stall", 64'(r_stalls), 64'd0);
        wait_drain(0);

        // Following matching frame forwarded intact.
        build(r_mac, 30);
        push_exp(0, 30, 1'b0, 30);
        drive_frame(0, 30, 1'b0, 30, r_stalls);
        wait_drain(0);

        // Promiscuous accepts a foreign address.
        r_promisc = 1'b1;
        build(48'h0A_0B_0C_0D_0E_0F, 12);
        push_exp(0, 12, 1'b0, 12);
        drive_frame(0, 12, 1'b0, 12, r_stalls);
        r_promisc = 1'b0;
        wait_drain(0);

        // Broadcast accepted.
        build(ETH_BCAST_ADDR, 20);
        push_exp(0, 20, 1'b0, 20);
        drive_frame(0, 20, 1'b0, 20, r_stalls);
        wait_drain(0);

        // Multicast rejected with multicast acceptance off.
        build(48'h01_00_5E_00_00_01, 20);
        drive_frame(0, 20, 1'b0, 20, r_stalls);
        check_val("mcast_off_no_stall", 64'(r_stalls), 64'd0);
        wait_drain(0);

        // 4-byte runt.
        build(r_mac, 4);
        drive_frame(0, 4, 1'b0, 4, r_stalls);
        wait_drain(0);
`ifdef ETH_RX_MAC_FILTER_STATS_EN
        check_val("runt4_stat_drop", 64'(w_drop0), 64'd3);
`endif

        // 5-byte runt carrying a matching prefix.
        build(r_mac, 5);
        drive_frame(0, 5, 1'b1, 5, r_stalls);
        wait_drain(0);

        // Exactly 6 bytes, matching, bad-frame flag set.
        build(r_mac, 6);
        push_exp(0, 6, 1'b1, 6);
        drive_frame(0, 6, 1'b1, 6, r_stalls);
        wait_drain(0);

        // 100-byte frame under random output backpressure, tuser on last.
        r_bp_en = 1'b1;
        build(r_mac, 100);
        push_exp(0, 100, 1'b1, 100);
        drive_frame(0, 100, 1'b1, 100, r_stalls);
        wait_drain(0);
        r_bp_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Multicast accepted on the multicast-enabled instance.
        build(48'h01_00_5E_00_00_01, 20);
        push_exp(1, 20, 1'b0, 20);
        drive_frame(1, 20, 1'b0, 20, r_stalls);
        wait_drain(1);

`ifdef ETH_RX_MAC_FILTER_STATS_EN
        check_val("dut0_stat_acc",  64'(w_acc0),  64'd6);
        check_val("dut0_stat_drop", 64'(w_drop0), 64'd4);
        check_val("dut1_stat_acc",  64'(w_acc1),  64'd1);
        check_val("dut1_stat_drop", 64'(w_drop1), 64'd0);
`endif

        // Reset one cycle after byte 20 of a passing frame is accepted.
        build(r_mac, 64);
        push_exp(0, 64, 1'b0, 21);
        drive_frame(0, 64, 1'b0, 21, r_stalls);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_val("midrst_m_tvalid", 64'(m0.tvalid), 64'd0);
        check_val("midrst_state",    64'(u_dut0.r_state), 64'(IDLE));
        check_val("midrst_q_empty",  64'(q0.size()), 64'd0);
`ifdef ETH_RX_MAC_FILTER_STATS_EN
        check_val("midrst_stat_acc",  64'(w_acc0),  64'd0);
        check_val("midrst_stat_drop", 64'(w_drop0), 64'd0);
`endif
        @(posedge clk);
        #1;

        // Recovery after reset.
        build(r_mac, 10);
        push_exp(0, 10, 1'b0, 10);
        drive_frame(0, 10, 1'b0, 10, r_stalls);
        wait_drain(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
